key_filter: RTL

//   Input-side conditioner for a mechanical push-button feeding the board logic.
//   - Synchronises the raw key pin and debounces it.
//   - Emits single-cycle press, release and long-press pulses and a clean level.
//   - Keeps a wrapping press counter.

---
 rtl/key_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/key_filter.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, press/release/long pulses
// and a wrapping press counter. Every output comes straight from a flop.
module key_filter #(
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned LONG_MAX   = 49_999_999,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic       key_state,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [7:0] press_cnt,
    output logic [1:0] dbg_state
);

    localparam int DW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int HW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
    localparam logic [DW-1:0] DCNT_END = DW'(CNT_MAX);
    localparam logic [HW-1:0] HCNT_END = HW'(LONG_MAX);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_FILT = 2'd3
    } state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_done_q, long_done_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          key_state_q, key_state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          k;

    assign k = (sync2_q == KEY_ACTIVE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q     <= ~KEY_ACTIVE;
            sync2_q     <= ~KEY_ACTIVE;
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (k) begin
                    state_d = PRESS_FILT;
                    dcnt_d  = '0;
                end
            end
            PRESS_FILT: begin
                if (!k) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_END) begin
                    state_d     = DOWN;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                    cnt_d       = cnt_q + 8'd1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DOWN: begin
                // Hold time saturates; the done flag keeps key_long to one pulse per press.
                if (hcnt_q != HCNT_END) hcnt_d = hcnt_q + 1'b1;
                else long_done_d = 1'b1;
                if (!k) begin
                    state_d = RELEASE_FILT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_FILT: begin
                if (k) begin
                    state_d = DOWN;
                end else if (dcnt_q == DCNT_END) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d     = (state_q == PRESS_FILT) && k && (dcnt_q == DCNT_END);
        release_d   = (state_q == RELEASE_FILT) && !k && (dcnt_q == DCNT_END);
        long_d      = (state_q == DOWN) && (hcnt_q == HCNT_END) && !long_done_q;
        key_state_d = key_state_q;
        if (press_d) key_state_d = 1'b1;
        else if (release_d) key_state_d = 1'b0;
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign press_cnt   = cnt_q;
    assign dbg_state   = state_q;

endmodule
